// File: rtl/mac_2bit_accumulator_pkg.sv
// Shared operand/product widths and FSM state encoding for the 2-bit MAC.
package mac_2bit_accumulator_pkg;
   localparam int OPND_W = 2;
   localparam int PROD_W = 4;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;
endpackage

// File: rtl/multiplier_2bit.sv
// Combinational 2x2-bit unsigned multiplier producing a 4-bit product.
module multiplier_2bit
   import mac_2bit_accumulator_pkg::*;
(
   input  logic [OPND_W-1:0] in1,
   input  logic [OPND_W-1:0] in2,
   output logic [PROD_W-1:0] prod
);
   // Operands are widened first so the product is computed at full width.
   assign prod = {{(PROD_W-OPND_W){1'b0}}, in1} * {{(PROD_W-OPND_W){1'b0}}, in2};
endmodule

// File: rtl/mac_2bit_accumulator.sv
// Dot-product accumulator: sums N_TERMS 2x2-bit products, presents the sum on a
// valid/ready output and flags any carry out of the accumulator during the result.
module mac_2bit_accumulator
   import mac_2bit_accumulator_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in1,
   input  logic [OPND_W-1:0] in2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf
);
   localparam int CNT_W = $clog2(N_TERMS + 1);

   state_t             state, state_n;
   logic [ACC_W-1:0]   acc, acc_n;
   logic [CNT_W-1:0]   count, count_n;
   logic               ovf_r, ovf_n;
   logic [PROD_W-1:0]  prod;
   logic [ACC_W:0]     sum;
   logic               accept;

   multiplier_2bit u_mult (
      .in1  (in1),
      .in2  (in2),
      .prod (prod)
   );

   // The extra top bit of sum is the carry out of the accumulator.
   assign sum       = {1'b0, acc} + (ACC_W+1)'(prod);
   assign in_ready  = (state == ST_ACCUM) && !rst && !clr;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);
   assign acc_out   = acc;
   assign ovf       = ovf_r;

   // Next-state, accumulate and clear decisions; clr beats accept, DONE ignores clr.
   always_comb begin
      state_n = state;
      acc_n   = acc;
      count_n = count;
      ovf_n   = ovf_r;
      case (state)
         ST_ACCUM: begin
            if (clr) begin
               acc_n   = '0;
               count_n = '0;
               ovf_n   = 1'b0;
            end else if (accept) begin
               acc_n   = sum[ACC_W-1:0];
               count_n = count + CNT_W'(1);
               ovf_n   = ovf_r | sum[ACC_W];
               if (count == CNT_W'(N_TERMS - 1))
                  state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               acc_n   = '0;
               count_n = '0;
               ovf_n   = 1'b0;
               state_n = ST_ACCUM;
            end
         end
         default: state_n = ST_ACCUM;
      endcase
   end

   // State register; synchronous reset discards any partial or pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ACCUM;
         acc   <= '0;
         count <= '0;
         ovf_r <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         count <= count_n;
         ovf_r <= ovf_n;
      end
   end
endmodule
